// File: rtl/wds_pkg.sv
// -----------------------------------------------------------------------------
// wds_pkg
// Shared definitions for the watchdog supervisor:
//   - wds_state_e : FSM state codes exported on the 'state' port
//   - FAULT_CNT_W / FAULT_CNT_MAX : trip counter width and saturation value
//   - cnt_w()     : width of a counter that must hold 0..n-1
// -----------------------------------------------------------------------------
package wds_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_RUN     = 3'd2,
        ST_FAULT   = 3'd3,
        ST_RECOVER = 3'd4
    } wds_state_e;

    localparam int                     FAULT_CNT_W   = 8;
    localparam logic [FAULT_CNT_W-1:0] FAULT_CNT_MAX = 8'd255;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wds_window_tracker.sv
// -----------------------------------------------------------------------------
// wds_window_tracker
// Counts fixed-length check-in windows and accumulates which required sources
// have pulsed 'alive' during the current window.
//
// Ports:
//   clk_i            system clock
//   rst_i            synchronous active-high reset
//   restart_i        holds the tracker at the start of a fresh window
//   src_mask_i       required sources, latched at each window start
//   alive_i          per-source liveness pulses
//   window_done_o    high on the final cycle of a window (1 cycle)
//   window_ok_o      verdict for the closing window (valid with window_done_o)
//   window_missed_o  required sources not heard in the closing window
// -----------------------------------------------------------------------------
module wds_window_tracker
    import wds_pkg::*;
#(
    parameter int N_SRC         = 4,
    parameter int WINDOW_CYCLES = 1000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             restart_i,
    input  logic [N_SRC-1:0] src_mask_i,
    input  logic [N_SRC-1:0] alive_i,
    output logic             window_done_o,
    output logic             window_ok_o,
    output logic [N_SRC-1:0] window_missed_o
);

    localparam int            WW       = cnt_w(WINDOW_CYCLES);
    localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW_CYCLES - 1);

    logic [WW-1:0]    win_cnt_q;
    logic [N_SRC-1:0] mask_l_q;
    logic [N_SRC-1:0] seen_q;
    logic [N_SRC-1:0] heard;

    // Pulses arriving on the final cycle still count for the closing window.
    assign heard           = seen_q | alive_i;
    assign window_done_o   = !restart_i && (win_cnt_q == WIN_LAST);
    assign window_ok_o     = (heard & mask_l_q) == mask_l_q;
    assign window_missed_o = mask_l_q & ~heard;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            win_cnt_q <= '0;
            mask_l_q  <= '0;
            seen_q    <= '0;
        end else if (restart_i || (win_cnt_q == WIN_LAST)) begin
            // Window start: fresh accumulator, mask sampled for the new window.
            win_cnt_q <= '0;
            mask_l_q  <= src_mask_i;
            seen_q    <= '0;
        end else begin
            win_cnt_q <= win_cnt_q + 1'b1;
            seen_q    <= seen_q | (alive_i & mask_l_q);
        end
    end

endmodule

// File: rtl/watchdog_supervisor.sv
// -----------------------------------------------------------------------------
// watchdog_supervisor
// Arms the board watchdog, feeds it one heartbeat per window in which every
// required liveness source checked in, and on a watchdog trip mutes RF and
// runs a force_reset recovery sequence.
//
// Ports:
//   clk             system clock
//   rst             synchronous active-high reset
//   arm             level; host requests supervised operation
//   src_mask        required sources (latched at each window start)
//   alive           per-source liveness pulses
//   clear_fault     pulse; acknowledges a trip (only honoured in FAULT)
//   wd_triggered    watchdog trip flag
//   wd_enable       watchdog enable
//   wd_heartbeat    1-cycle heartbeat to the watchdog
//   wd_force_reset  watchdog force_reset
//   rf_mute         RF output mute
//   state           FSM state code (wds_state_e)
//   missed_src      sources missing in the most recent failed window
//   fault_count     trip count, saturating at 255
//
// Build option:
//   WDS_AUTO_RECOVER_EN  when defined, FAULT also exits to RECOVER after
//                        HOLDOFF_CYCLES cycles without clear_fault. When not
//                        defined, HOLDOFF_CYCLES has no effect.
// -----------------------------------------------------------------------------
module watchdog_supervisor
    import wds_pkg::*;
#(
    parameter int N_SRC              = 4,
    parameter int WINDOW_CYCLES      = 1000,
    parameter int RESET_PULSE_CYCLES = 4,
    parameter int HOLDOFF_CYCLES     = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   arm,
    input  logic [N_SRC-1:0]       src_mask,
    input  logic [N_SRC-1:0]       alive,
    input  logic                   clear_fault,
    input  logic                   wd_triggered,
    output logic                   wd_enable,
    output logic                   wd_heartbeat,
    output logic                   wd_force_reset,
    output logic                   rf_mute,
    output logic [2:0]             state,
    output logic [N_SRC-1:0]       missed_src,
    output logic [FAULT_CNT_W-1:0] fault_count
);

    localparam int            PW         = cnt_w(RESET_PULSE_CYCLES);
    localparam logic [PW-1:0] PULSE_LAST = PW'(RESET_PULSE_CYCLES - 1);
    localparam int            HW         = cnt_w(HOLDOFF_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLDOFF_CYCLES - 1);

`ifdef WDS_AUTO_RECOVER_EN
    localparam bit AUTO_RECOVER = 1'b1;
`else
    localparam bit AUTO_RECOVER = 1'b0;
`endif

    wds_state_e             state_q;
    logic                   wd_enable_q;
    logic                   wd_heartbeat_q;
    logic                   wd_force_reset_q;
    logic                   rf_mute_q;
    logic [N_SRC-1:0]       missed_src_q;
    logic [FAULT_CNT_W-1:0] fault_cnt_q;
    logic [FAULT_CNT_W-1:0] fault_cnt_d;
    logic [PW-1:0]          pulse_cnt_q;
    logic [HW-1:0]          hold_cnt_q;

    logic             window_done;
    logic             window_ok;
    logic [N_SRC-1:0] window_missed;
    logic             holdoff_done;

    // Tracker sits at a fresh window whenever we are not in RUN, so the
    // first RUN cycle is always window cycle 0 with an empty accumulator.
    wds_window_tracker #(
        .N_SRC         (N_SRC),
        .WINDOW_CYCLES (WINDOW_CYCLES)
    ) u_tracker (
        .clk_i           (clk),
        .rst_i           (rst),
        .restart_i       (state_q != ST_RUN),
        .src_mask_i      (src_mask),
        .alive_i         (alive),
        .window_done_o   (window_done),
        .window_ok_o     (window_ok),
        .window_missed_o (window_missed)
    );

    assign holdoff_done = AUTO_RECOVER && (hold_cnt_q == HOLD_LAST);

    always_comb begin
        fault_cnt_d = fault_cnt_q;
        if (fault_cnt_q != FAULT_CNT_MAX) begin
            fault_cnt_d = fault_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            wd_enable_q      <= 1'b0;
            wd_heartbeat_q   <= 1'b0;
            wd_force_reset_q <= 1'b0;
            rf_mute_q        <= 1'b1;
            missed_src_q     <= '0;
            fault_cnt_q      <= '0;
            pulse_cnt_q      <= '0;
            hold_cnt_q       <= '0;
        end else begin
            wd_heartbeat_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    wd_enable_q      <= 1'b0;
                    wd_force_reset_q <= 1'b0;
                    rf_mute_q        <= 1'b1;
                    if (arm) begin
                        state_q          <= ST_ARM;
                        wd_enable_q      <= 1'b1;
                        wd_force_reset_q <= 1'b1;
                        pulse_cnt_q      <= '0;
                    end
                end

                ST_ARM: begin
                    if (pulse_cnt_q == PULSE_LAST) begin
                        state_q          <= ST_RUN;
                        wd_force_reset_q <= 1'b0;
                        wd_heartbeat_q   <= 1'b1;
                        rf_mute_q        <= 1'b0;
                    end else begin
                        pulse_cnt_q <= pulse_cnt_q + 1'b1;
                    end
                end

                ST_RUN: begin
                    if (window_done && !window_ok) begin
                        missed_src_q <= window_missed;
                    end
                    // A trip outranks arm dropping in the same cycle.
                    if (wd_triggered) begin
                        state_q     <= ST_FAULT;
                        rf_mute_q   <= 1'b1;
                        fault_cnt_q <= fault_cnt_d;
                        hold_cnt_q  <= '0;
                    end else if (!arm) begin
                        state_q     <= ST_IDLE;
                        wd_enable_q <= 1'b0;
                        rf_mute_q   <= 1'b1;
                    end else if (window_done && window_ok) begin
                        wd_heartbeat_q <= 1'b1;
                    end
                end

                ST_FAULT: begin
                    if (clear_fault || holdoff_done) begin
                        state_q          <= ST_RECOVER;
                        wd_force_reset_q <= 1'b1;
                        pulse_cnt_q      <= '0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end

                ST_RECOVER: begin
                    if (pulse_cnt_q == PULSE_LAST) begin
                        wd_force_reset_q <= 1'b0;
                        if (arm) begin
                            state_q        <= ST_RUN;
                            wd_heartbeat_q <= 1'b1;
                            rf_mute_q      <= 1'b0;
                        end else begin
                            state_q     <= ST_IDLE;
                            wd_enable_q <= 1'b0;
                        end
                    end else begin
                        pulse_cnt_q <= pulse_cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign wd_enable      = wd_enable_q;
    assign wd_heartbeat   = wd_heartbeat_q;
    assign wd_force_reset = wd_force_reset_q;
    assign rf_mute        = rf_mute_q;
    assign state          = state_q;
    assign missed_src     = missed_src_q;
    assign fault_count    = fault_cnt_q;

endmodule

// File: tb/tb_watchdog_supervisor.sv
module tb_watchdog_supervisor;

    localparam int N_SRC              = 4;
    localparam int WINDOW_CYCLES      = 8;
    localparam int RESET_PULSE_CYCLES = 4;
    localparam int HOLDOFF_CYCLES     = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             arm;
    logic [N_SRC-1:0] src_mask;
    logic [N_SRC-1:0] alive;
    logic             clear_fault;
    logic             wd_triggered;
    logic             wd_enable;
    logic             wd_heartbeat;
    logic             wd_force_reset;
    logic             rf_mute;
    logic [2:0]       state;
    logic [N_SRC-1:0] missed_src;
    logic [7:0]       fault_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    watchdog_supervisor #(
        .N_SRC              (N_SRC),
        .WINDOW_CYCLES      (WINDOW_CYCLES),
        .RESET_PULSE_CYCLES (RESET_PULSE_CYCLES),
        .HOLDOFF_CYCLES     (HOLDOFF_CYCLES)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .arm            (arm),
        .src_mask       (src_mask),
        .alive          (alive),
        .clear_fault    (clear_fault),
        .wd_triggered   (wd_triggered),
        .wd_enable      (wd_enable),
        .wd_heartbeat   (wd_heartbeat),
        .wd_force_reset (wd_force_reset),
        .rf_mute        (rf_mute),
        .state          (state),
        .missed_src     (missed_src),
        .fault_count    (fault_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are observed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count observed cycles with force_reset high, starting at the current one.
    task automatic count_force(input bit pulse_wdt, output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!wd_force_reset) break;
            n++;
            if (i == 0 && pulse_wdt) wd_triggered = 1'b1;
            tick();
            wd_triggered = 1'b0;
        end
    endtask

    // One full window starting at window cycle 0. a_early is pulsed on
    // cycle 2, a_last on the final cycle.
    task automatic run_window(input logic [N_SRC-1:0] a_early, input logic [N_SRC-1:0] a_last,
                              output int hb_total, output logic hb_last);
        hb_total = 0;
        hb_last  = 1'b0;
        for (int c = 0; c < WINDOW_CYCLES; c++) begin
            alive = (c == 2) ? a_early : ((c == WINDOW_CYCLES - 1) ? a_last : '0);
            tick();
            if (wd_heartbeat) hb_total++;
            hb_last = wd_heartbeat;
        end
        alive = '0;
    endtask

    task automatic trip_and_recover();
        wd_triggered = 1'b1;
        tick();
        wd_triggered = 1'b0;
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        repeat (RESET_PULSE_CYCLES) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   n;
        int   hbt;
        logic hbl;

        rst          = 1'b1;
        arm          = 1'b0;
        src_mask     = 4'b1111;
        alive        = '0;
        clear_fault  = 1'b0;
        wd_triggered = 1'b0;
        repeat (2) tick();

        chk("rst_state",  32'(state), 32'd0);
        chk("rst_en",     32'(wd_enable), 32'd0);
        chk("rst_hb",     32'(wd_heartbeat), 32'd0);
        chk("rst_fr",     32'(wd_force_reset), 32'd0);
        chk("rst_mute",   32'(rf_mute), 32'd1);
        chk("rst_missed", 32'(missed_src), 32'd0);
        chk("rst_fcnt",   32'(fault_count), 32'd0);

        // Arm: 4-cycle force_reset, then heartbeat on RUN entry.
        rst = 1'b0;
        arm = 1'b1;
        tick();
        chk("arm_state", 32'(state), 32'd1);
        chk("arm_en",    32'(wd_enable), 32'd1);
        count_force(1'b0, n);
        chk("arm_fr_len",   32'(n), 32'd4);
        chk("run_state",    32'(state), 32'd2);
        chk("run_entry_hb", 32'(wd_heartbeat), 32'd1);
        chk("run_mute",     32'(rf_mute), 32'd0);

        // All sources alive each window: one heartbeat per window, at its end.
        run_window(4'b1111, 4'b0000, hbt, hbl);
        chk("w1_hb_last",  32'(hbl), 32'd1);
        chk("w1_hb_total", 32'(hbt), 32'd1);
        run_window(4'b0000, 4'b1111, hbt, hbl);
        chk("w2_lastcyc_hb", 32'(hbl), 32'd1);
        chk("w2_missed",     32'(missed_src), 32'd0);
        chk("w2_mute",       32'(rf_mute), 32'd0);

        // Source 2 silent: no heartbeat, missed_src flags it.
        run_window(4'b1011, 4'b0000, hbt, hbl);
        chk("w3_hb_total", 32'(hbt), 32'd0);
        chk("w3_missed",   32'(missed_src), 32'h4);
        // Source 2 checks in on the final cycle: heartbeat, missed_src held.
        run_window(4'b1011, 4'b0100, hbt, hbl);
        chk("w4_hb_last", 32'(hbl), 32'd1);
        chk("w4_missed",  32'(missed_src), 32'h4);

        // Empty mask: every window passes (mask takes effect next window).
        src_mask = 4'b0000;
        run_window(4'b1111, 4'b0000, hbt, hbl);
        chk("w5_hb_last", 32'(hbl), 32'd1);
        src_mask = 4'b1111;
        run_window(4'b0000, 4'b0000, hbt, hbl);
        chk("w6_mask0_hb", 32'(hbl), 32'd1);
        run_window(4'b1111, 4'b0000, hbt, hbl);
        chk("w7_hb_last", 32'(hbl), 32'd1);

        // Trip in RUN.
        wd_triggered = 1'b1;
        tick();
        wd_triggered = 1'b0;
        chk("trip_state", 32'(state), 32'd3);
        chk("trip_mute",  32'(rf_mute), 32'd1);
        chk("trip_fcnt",  32'(fault_count), 32'd1);
        chk("trip_en",    32'(wd_enable), 32'd1);
        hbt = 0;
        arm = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (wd_heartbeat) hbt++;
        end
        arm = 1'b1;
        chk("fault_no_hb",      32'(hbt), 32'd0);
        chk("fault_ignore_arm", 32'(state), 32'd3);
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        chk("recover_state", 32'(state), 32'd4);
        count_force(1'b1, n);
        chk("recover_fr_len", 32'(n), 32'd4);
        chk("recover_run",    32'(state), 32'd2);
        chk("recover_hb",     32'(wd_heartbeat), 32'd1);

        // clear_fault outside FAULT is ignored.
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        chk("clear_in_run", 32'(state), 32'd2);

        // Trip and arm drop together -> FAULT wins.
        wd_triggered = 1'b1;
        arm          = 1'b0;
        tick();
        wd_triggered = 1'b0;
        arm          = 1'b1;
        chk("trip_arm0_state", 32'(state), 32'd3);
        chk("trip_arm0_fcnt",  32'(fault_count), 32'd2);
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        count_force(1'b0, n);
        chk("recover2_fr_len", 32'(n), 32'd4);
        chk("recover2_run",    32'(state), 32'd2);

        // Saturation: 255 trips then one more.
        for (int i = 0; i < 253; i++) trip_and_recover();
        chk("fcnt_255", 32'(fault_count), 32'd255);
        chk("sat_run",  32'(state), 32'd2);
        trip_and_recover();
        chk("fcnt_sat", 32'(fault_count), 32'd255);

        // arm low in RUN -> IDLE.
        arm = 1'b0;
        tick();
        chk("disarm_state", 32'(state), 32'd0);
        chk("disarm_en",    32'(wd_enable), 32'd0);
        chk("disarm_mute",  32'(rf_mute), 32'd1);
        arm = 1'b1;
        tick();
        count_force(1'b0, n);
        chk("rearm_fr_len", 32'(n), 32'd4);

        // Trip with no acknowledge.
        wd_triggered = 1'b1;
        tick();
        wd_triggered = 1'b0;
        chk("trip3_state", 32'(state), 32'd3);
`ifdef WDS_AUTO_RECOVER_EN
        n = 0;
        while (state == 3'd3 && n < 40) begin
            tick();
            n++;
        end
        chk("auto_recover_delay", 32'(n), 32'd16);
        chk("auto_recover_state", 32'(state), 32'd4);
`else
        repeat (40) tick();
        chk("no_auto_recover", 32'(state), 32'd3);
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        chk("recover3_state", 32'(state), 32'd4);
`endif

        // Reset in the middle of RECOVER.
        tick();
        chk("pre_rst_fr", 32'(wd_force_reset), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        arm = 1'b0;
        chk("midrst_state", 32'(state), 32'd0);
        chk("midrst_fr",    32'(wd_force_reset), 32'd0);
        chk("midrst_mute",  32'(rf_mute), 32'd1);
        chk("midrst_fcnt",  32'(fault_count), 32'd0);
        chk("midrst_en",    32'(wd_enable), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
